// File: rtl/ysyx_220066_pkg.sv
// ysyx_220066_pkg: shared encodings for the EX-stage ALU and next-PC logic.
//   aluctr encodings: [4] word mode (ALU_W), [3] variant, [2:0] function.
//   Branch encodings: control-transfer type consumed by the next-PC block.
package ysyx_220066_pkg;

  localparam int XLEN = 64;

  // aluctr function codes (word mode is OR-ed in with ALU_W)
  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SLL   = 5'b00001;
  localparam logic [4:0] ALU_SLT   = 5'b00010;
  localparam logic [4:0] ALU_SLTU  = 5'b00011;
  localparam logic [4:0] ALU_XOR   = 5'b00100;
  localparam logic [4:0] ALU_SRL   = 5'b00101;
  localparam logic [4:0] ALU_OR    = 5'b00110;
  localparam logic [4:0] ALU_AND   = 5'b00111;
  localparam logic [4:0] ALU_SUB   = 5'b01000;
  localparam logic [4:0] ALU_COPYA = 5'b01001;
  localparam logic [4:0] ALU_COPYB = 5'b01010;
  localparam logic [4:0] ALU_ANDN  = 5'b01011;
  localparam logic [4:0] ALU_SRA   = 5'b01101;
  localparam logic [4:0] ALU_W     = 5'b10000;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_JAL  = 3'b001,
    BR_JALR = 3'b010,
    BR_RSV  = 3'b011,
    BR_EQ   = 3'b100,
    BR_NE   = 3'b101,
    BR_LT   = 3'b110,
    BR_GE   = 3'b111
  } br_e;

endpackage

// File: rtl/ysyx_220066_nxt_pc.sv
// ysyx_220066_nxt_pc: branch/jump resolution and next-PC selection.
// Ports:
//   in_pc   - PC of the instruction in EX
//   BusA    - rs1 value, JALR base
//   Imm     - sign-extended immediate
//   Branch  - control-transfer type (br_e encoding)
//   zero    - ALU result == 0 (BEQ/BNE)
//   res_lsb - ALU result[0] (SLT/SLTU outcome for BLT/BGE)
//   nxtpc   - next PC
//   is_jmp  - control transfer taken
module ysyx_220066_nxt_pc
  import ysyx_220066_pkg::*;
(
  input  logic [63:0] in_pc,
  input  logic [63:0] BusA,
  input  logic [63:0] Imm,
  input  logic [2:0]  Branch,
  input  logic        zero,
  input  logic        res_lsb,
  output logic [63:0] nxtpc,
  output logic        is_jmp
);

  logic [63:0] br_tgt_s;
  logic [63:0] jalr_sum_s;
  logic [63:0] seq_pc_s;
  logic        taken_s;

  // All three candidate targets are computed in parallel so only the
  // taken decode (which waits on the ALU flags) sits on the late path.
  assign br_tgt_s   = in_pc + Imm;
  assign jalr_sum_s = BusA + Imm;
  assign seq_pc_s   = in_pc + 64'd4;

  // Taken decode from branch type and ALU flags
  always_comb begin
    taken_s = 1'b0;
    case (br_e'(Branch))
      BR_JAL:  taken_s = 1'b1;
      BR_JALR: taken_s = 1'b1;
      BR_EQ:   taken_s = zero;
      BR_NE:   taken_s = ~zero;
      BR_LT:   taken_s = res_lsb;
      BR_GE:   taken_s = ~res_lsb;
      default: taken_s = 1'b0;
    endcase
  end

  // Next-PC mux: JALR clears bit 0, other taken transfers use in_pc + Imm
  always_comb begin
    nxtpc = seq_pc_s;
    if (br_e'(Branch) == BR_JALR) begin
      nxtpc = {jalr_sum_s[63:1], 1'b0};
    end else if (taken_s) begin
      nxtpc = br_tgt_s;
    end else begin
      nxtpc = seq_pc_s;
    end
  end

  assign is_jmp = taken_s;

endmodule

// File: rtl/ysyx_220066_alu_nxtpc.sv
// ysyx_220066_alu_nxtpc: RV64 EX-stage datapath, 64-bit ALU with W-suffix
// variants plus next-PC/branch resolution. Datapath is fully combinational.
// Ports:
//   clk, rst     - stage clock / sync active-high reset (trace only)
//   data_input   - operand A;  datab_input - operand B
//   aluctr       - [4] word mode, [3] variant, [2:0] function
//   result, zero - ALU result and (result == 0)
//   add_lowbit   - adder output [2:0] (store byte-lane select)
//   in_pc, BusA, Imm, Branch - next-PC inputs
//   nxtpc, is_jmp            - next PC and taken flag
// Optional: define YSYX_220066_ALU_TRACE_EN to print a per-cycle trace.
module ysyx_220066_alu_nxtpc
  import ysyx_220066_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_input,
  input  logic [63:0] datab_input,
  input  logic [4:0]  aluctr,
  output logic [63:0] result,
  output logic        zero,
  output logic [2:0]  add_lowbit,
  input  logic [63:0] in_pc,
  input  logic [63:0] BusA,
  input  logic [63:0] Imm,
  input  logic [2:0]  Branch,
  output logic [63:0] nxtpc,
  output logic        is_jmp
);

  logic               word_s;
  logic               sub_s;
  logic [63:0]        b_add_s;
  logic [63:0]        sum_s;
  logic [5:0]         shamt_s;
  logic [63:0]        a_ext_s;
  logic [63:0]        b_ext_s;
  logic [63:0]        a_srl_s;
  logic signed [63:0] sra_s;
  logic [63:0]        raw_s;

  assign word_s = aluctr[4];
  assign sub_s  = (aluctr[3:0] == ALU_SUB[3:0]);

  // Single shared adder; SUB is A + ~B + 1. Low 32 bits are the W result.
  assign b_add_s    = sub_s ? ~datab_input : datab_input;
  assign sum_s      = data_input + b_add_s + {63'd0, sub_s};
  assign add_lowbit = sum_s[2:0];

  // In word mode operands are sign-extended from bit 31 so that signed and
  // unsigned compares and the arithmetic shift see the 32-bit values; the
  // unsigned order of sign-extended words matches their 32-bit order.
  assign shamt_s = word_s ? {1'b0, datab_input[4:0]} : datab_input[5:0];
  assign a_ext_s = word_s ? {{32{data_input[31]}}, data_input[31:0]} : data_input;
  assign b_ext_s = word_s ? {{32{datab_input[31]}}, datab_input[31:0]} : datab_input;
  assign a_srl_s = word_s ? {32'd0, data_input[31:0]} : data_input;
  assign sra_s   = $signed(a_ext_s) >>> shamt_s;

  // Function select; reserved variant codes fall back to the ADD result
  always_comb begin
    raw_s = sum_s;
    case (aluctr[3:0])
      ALU_ADD[3:0]:   raw_s = sum_s;
      ALU_SLL[3:0]:   raw_s = a_ext_s << shamt_s;
      ALU_SLT[3:0]:   raw_s = {63'd0, ($signed(a_ext_s) < $signed(b_ext_s))};
      ALU_SLTU[3:0]:  raw_s = {63'd0, (a_ext_s < b_ext_s)};
      ALU_XOR[3:0]:   raw_s = a_ext_s ^ b_ext_s;
      ALU_SRL[3:0]:   raw_s = a_srl_s >> shamt_s;
      ALU_OR[3:0]:    raw_s = a_ext_s | b_ext_s;
      ALU_AND[3:0]:   raw_s = a_ext_s & b_ext_s;
      ALU_SUB[3:0]:   raw_s = sum_s;
      ALU_SRA[3:0]:   raw_s = sra_s;
      ALU_COPYB[3:0]: raw_s = b_ext_s;
      ALU_ANDN[3:0]:  raw_s = a_ext_s & ~b_ext_s;
      ALU_COPYA[3:0]: raw_s = a_ext_s;
      default:        raw_s = sum_s;
    endcase
  end

  // Word results are sign-extended from bit 31 before the zero test
  always_comb begin
    result = raw_s;
    if (word_s) begin
      result = {{32{raw_s[31]}}, raw_s[31:0]};
    end else begin
      result = raw_s;
    end
  end

  assign zero = (result == 64'd0);

  ysyx_220066_nxt_pc u_nxt_pc (
    .in_pc   (in_pc),
    .BusA    (BusA),
    .Imm     (Imm),
    .Branch  (Branch),
    .zero    (zero),
    .res_lsb (result[0]),
    .nxtpc   (nxtpc),
    .is_jmp  (is_jmp)
  );

`ifdef YSYX_220066_ALU_TRACE_EN
  // Per-cycle execution trace
  always_ff @(posedge clk) begin
    if (!rst) begin
      $display("alu: ctr=%b A=%h B=%h res=%h zero=%b br=%b nxtpc=%h jmp=%b",
               aluctr, data_input, datab_input, result, zero, Branch, nxtpc, is_jmp);
    end
  end
`else
  // Clock and reset have no function without the trace
  logic unused_clk_rst_s;
  assign unused_clk_rst_s = clk ^ rst;
`endif

endmodule

// File: tb/tb_ysyx_220066_alu_nxtpc.sv
// Directed-vector bench for ysyx_220066_alu_nxtpc with hand-computed values.
module tb_ysyx_220066_alu_nxtpc;
  import ysyx_220066_pkg::*;

  logic        clk;
  logic        rst;
  logic [63:0] data_input;
  logic [63:0] datab_input;
  logic [4:0]  aluctr;
  logic [63:0] result;
  logic        zero;
  logic [2:0]  add_lowbit;
  logic [63:0] in_pc;
  logic [63:0] BusA;
  logic [63:0] Imm;
  logic [2:0]  Branch;
  logic [63:0] nxtpc;
  logic        is_jmp;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_220066_alu_nxtpc dut (
    .clk         (clk),
    .rst         (rst),
    .data_input  (data_input),
    .datab_input (datab_input),
    .aluctr      (aluctr),
    .result      (result),
    .zero        (zero),
    .add_lowbit  (add_lowbit),
    .in_pc       (in_pc),
    .BusA        (BusA),
    .Imm         (Imm),
    .Branch      (Branch),
    .nxtpc       (nxtpc),
    .is_jmp      (is_jmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the ALU, let the combinational outputs settle away from clk edges
  task automatic alu(input logic [4:0] ctr, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    aluctr      = ctr;
    data_input  = a;
    datab_input = b;
    #1;
  endtask

  task automatic pc(input logic [2:0] br, input logic [63:0] p, input logic [63:0] bus_a,
                    input logic [63:0] imm);
    Branch = br;
    in_pc  = p;
    BusA   = bus_a;
    Imm    = imm;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    aluctr = 5'd0; data_input = 64'd0; datab_input = 64'd0;
    in_pc = 64'd0; BusA = 64'd0; Imm = 64'd0; Branch = 3'd0;
    repeat (2) @(posedge clk);
    rst = 1'b0;

    // Idle inputs: ADD 0+0, no branch
    alu(ALU_ADD, 64'd0, 64'd0);
    check_eq("idle_result", result, 64'd0);
    check_eq("idle_zero", {63'd0, zero}, 64'd1);
    check_eq("idle_nxtpc", nxtpc, 64'd4);
    check_eq("idle_jmp", {63'd0, is_jmp}, 64'd0);

    // ADDW overflow into bit 31 sign-extends
    alu(ALU_ADD | ALU_W, 64'h7FFF_FFFF, 64'd1);
    check_eq("addw_res", result, 64'hFFFF_FFFF_8000_0000);
    check_eq("addw_zero", {63'd0, zero}, 64'd0);
    // ADDW wrap to zero although 64-bit sum is non-zero
    alu(ALU_ADD | ALU_W, 64'hFFFF_FFFF, 64'd1);
    check_eq("addw_wrap_res", result, 64'd0);
    check_eq("addw_wrap_zero", {63'd0, zero}, 64'd1);

    // SUB equal, BEQ taken backwards
    alu(ALU_SUB, 64'h1234, 64'h1234);
    pc(3'b100, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8);
    check_eq("sub_zero", {63'd0, zero}, 64'd1);
    check_eq("beq_jmp", {63'd0, is_jmp}, 64'd1);
    check_eq("beq_nxtpc", nxtpc, 64'h7FFF_FFF8);
    // BNE on the same flags is not taken
    pc(3'b101, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8);
    check_eq("bne_nt_jmp", {63'd0, is_jmp}, 64'd0);
    check_eq("bne_nt_nxtpc", nxtpc, 64'h8000_0004);

    // SUB lane select: 8-3 = 5
    alu(ALU_SUB, 64'd8, 64'd3);
    check_eq("sub_lowbit", {61'd0, add_lowbit}, 64'd5);
    check_eq("sub_res", result, 64'd5);

    // SLT vs SLTU with BLT
    alu(ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    pc(3'b110, 64'h1000, 64'd0, 64'h20);
    check_eq("slt_res", result, 64'd1);
    check_eq("blt_jmp", {63'd0, is_jmp}, 64'd1);
    check_eq("blt_nxtpc", nxtpc, 64'h1020);
    alu(ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    check_eq("sltu_res", result, 64'd0);
    check_eq("bltu_jmp", {63'd0, is_jmp}, 64'd0);
    check_eq("bltu_nxtpc", nxtpc, 64'h1004);
    // BGEU on the same result is taken
    pc(3'b111, 64'h1000, 64'd0, 64'h20);
    check_eq("bge_jmp", {63'd0, is_jmp}, 64'd1);
    check_eq("bge_nxtpc", nxtpc, 64'h1020);
    // SLTW sees bit 31 as the sign
    alu(ALU_SLT | ALU_W, 64'h8000_0000, 64'd0);
    check_eq("sltw_res", result, 64'd1);

    // Shifts
    alu(ALU_SRA, 64'h8000_0000_0000_0000, 64'd63);
    check_eq("sra_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
    alu(ALU_SRA | ALU_W, 64'h8000_0000, 64'd4);
    check_eq("sraw_res", result, 64'hFFFF_FFFF_F800_0000);
    alu(ALU_SRL, 64'h8000_0000_0000_0000, 64'd63);
    check_eq("srl_res", result, 64'd1);
    alu(ALU_SRL | ALU_W, 64'hFFFF_FFFF_8000_0000, 64'd4);
    check_eq("srlw_res", result, 64'h0800_0000);
    alu(ALU_SLL, 64'd1, 64'h43);
    check_eq("sll_res", result, 64'd8);
    alu(ALU_SLL | ALU_W, 64'd1, 64'd33);
    check_eq("sllw_res", result, 64'd2);

    // Logic and copy ops
    alu(ALU_XOR, 64'hF0F0, 64'hFF00);
    check_eq("xor_res", result, 64'h0FF0);
    alu(ALU_OR, 64'hF0F0, 64'hFF00);
    check_eq("or_res", result, 64'hFFF0);
    alu(ALU_AND, 64'hF0F0, 64'hFF00);
    check_eq("and_res", result, 64'hF000);
    alu(ALU_ANDN, 64'hFF, 64'h0F);
    check_eq("andn_res", result, 64'hF0);
    alu(ALU_COPYA, 64'h1234_5678_9ABC_DEF0, 64'd7);
    check_eq("copya_res", result, 64'h1234_5678_9ABC_DEF0);
    alu(ALU_COPYB, 64'd7, 64'hDEAD_0000_BEEF);
    check_eq("copyb_res", result, 64'hDEAD_0000_BEEF);

    // JAL, JALR
    pc(3'b001, 64'h100, 64'd0, 64'h40);
    check_eq("jal_jmp", {63'd0, is_jmp}, 64'd1);
    check_eq("jal_nxtpc", nxtpc, 64'h140);
    pc(3'b010, 64'h100, 64'h8000_0101, 64'd4);
    check_eq("jalr_jmp", {63'd0, is_jmp}, 64'd1);
    check_eq("jalr_nxtpc", nxtpc, 64'h8000_0104);

    // Store lane select
    alu(ALU_ADD, 64'h1003, 64'd2);
    check_eq("add_lowbit", {61'd0, add_lowbit}, 64'd5);
    check_eq("add_res", result, 64'h1005);

    // Reserved branch and ALU codes
    pc(3'b011, 64'h200, 64'd0, 64'h40);
    check_eq("rsv_br_jmp", {63'd0, is_jmp}, 64'd0);
    check_eq("rsv_br_nxtpc", nxtpc, 64'h204);
    alu(5'b01100, 64'd2, 64'd3);
    check_eq("rsv_alu_res", result, 64'd5);

    // Reset activity must not disturb any output
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hi_res", result, 64'd5);
    check_eq("rst_hi_nxtpc", nxtpc, 64'h204);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_lo_res", result, 64'd5);
    check_eq("rst_lo_lowbit", {61'd0, add_lowbit}, 64'd5);
    check_eq("rst_lo_jmp", {63'd0, is_jmp}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
